ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/uproc_pkg.sv | 28 ++
 rtl/ifetch_decode.sv | 27 ++
 rtl/ifetch.sv | 108 ++++++++++
 tb/tb_ifetch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uproc_pkg.sv
// Shared opcode, register and fetch-FSM definitions for the micro-sequencer.
// Pure declarations; no latency, no backpressure.
// Imported by every ifetch file.
package uproc_pkg;

    localparam logic [3:0] OPCODE_NOP  = 4'h0;
    localparam logic [3:0] OPCODE_ADD  = 4'h1;
    localparam logic [3:0] OPCODE_SUB  = 4'h2;
    localparam logic [3:0] OPCODE_AND  = 4'h3;
    localparam logic [3:0] OPCODE_HALT = 4'hF;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ifetch_decode.sv
// Combinational opcode classifier: exactly one of alu/nop/halt/undef is high.
// Zero latency.
// No backpressure; pure function of opcode.
module ifetch_decode
    import uproc_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_nop,
    output logic       is_halt,
    output logic       is_undef
);

    always_comb begin
        is_alu   = 1'b0;
        is_nop   = 1'b0;
        is_halt  = 1'b0;
        is_undef = 1'b0;
        case (opcode)
            OPCODE_NOP:                        is_nop   = 1'b1;
            OPCODE_ADD, OPCODE_SUB, OPCODE_AND: is_alu  = 1'b1;
            OPCODE_HALT:                       is_halt  = 1'b1;
            default:                           is_undef = 1'b1;
        endcase
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch/issue sequencer: walks program memory, skips NOPs, issues ALU ops.
// run -> first issue valid two cycles later; one issue per two cycles at best.
// Holds op/rsel with ins_valid high indefinitely while ins_ready is low.
module ifetch
    import uproc_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int INS_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] addr,
    input  logic [INS_W-1:0]  ins_in,
    output logic [3:0]        op,
    output logic [1:0]        rsel,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic              halted,
    output logic              err,
    output logic [7:0]        icount
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        ir_op;
    logic [1:0]        ir_rsel;

    logic [3:0]        fetch_op;
    logic [1:0]        fetch_rsel;
    logic [ADDR_W-1:0] pc_inc;
    logic              is_alu;
    logic              is_nop;
    logic              is_halt;
    logic              is_undef;

    assign fetch_op   = ins_in[INS_W-1 -: 4];
    assign fetch_rsel = ins_in[1:0];
    assign pc_inc     = pc + ADDR_W'(1);

    ifetch_decode u_decode (
        .opcode   (fetch_op),
        .is_alu   (is_alu),
        .is_nop   (is_nop),
        .is_halt  (is_halt),
        .is_undef (is_undef)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc      <= '0;
            ir_op   <= OPCODE_NOP;
            ir_rsel <= R0;
            err     <= 1'b0;
            icount  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pc <= '0;
                    if (run) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Only ALU ops carry a meaningful rsel; undefined opcodes are
                    // recorded as NOP so garbage never reaches op/rsel.
                    ir_op   <= is_undef ? OPCODE_NOP : fetch_op;
                    ir_rsel <= is_alu ? fetch_rsel : R0;
                    if (is_alu) begin
                        state <= ST_ISSUE;
                    end else if (is_halt) begin
                        state <= ST_HALT;
                    end else begin
                        pc <= pc_inc;
                        if (is_undef) begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (ins_ready) begin
                        pc     <= pc_inc;
                        icount <= sat_inc8(icount);
                        state  <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (!run) begin
                        pc    <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign addr      = pc;
    assign op        = ir_op;
    assign rsel      = ir_rsel;
    assign ins_valid = (state == ST_ISSUE);
    assign halted    = (state == ST_HALT);

    logic unused_nop;
    assign unused_nop = is_nop;

endmodule

// File: tb/tb_ifetch.sv
// Scoreboarded bench for ifetch: expected issues queued per program, popped on handshake.
module tb_ifetch;
    import uproc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       ins_ready;
    logic [4:0] addr;
    logic [5:0] ins_in;
    logic [3:0] op;
    logic [1:0] rsel;
    logic       ins_valid;
    logic       halted;
    logic       err;
    logic [7:0] icount;

    ifetch #(.ADDR_W(5), .INS_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .addr      (addr),
        .ins_in    (ins_in),
        .op        (op),
        .rsel      (rsel),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .halted    (halted),
        .err       (err),
        .icount    (icount)
    );

    always #5 clk = ~clk;

    logic [5:0] mem [32];
    assign ins_in = mem[addr];

    typedef struct packed {
        logic [4:0] a;
        logic [3:0] op;
        logic [1:0] rs;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   last_hs = 0;
    int   hs_n    = 0;
    bit   spc_en  = 1'b0;
    bit   mon_en  = 1'b1;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [5:0] ins(input logic [3:0] o, input logic [1:0] r);
        return {o, r};
    endfunction

    task automatic push(input int a, input logic [3:0] o, input logic [1:0] r);
        exp_t e;
        e.a  = a[4:0];
        e.op = o;
        e.rs = r;
        sbq.push_back(e);
    endtask

    // Evaluated just before the edge, so valid&&ready here is a real handshake.
    task automatic mon();
        exp_t e;
        if (mon_en && ins_valid === 1'b1 && ins_ready && !rst) begin
            if (sbq.size() == 0) begin
                check("unexpected_issue", addr, -1);
            end else begin
                e = sbq.pop_front();
                check("issue_addr", addr, e.a);
                check("issue_op", op, e.op);
                check("issue_rsel", rsel, e.rs);
            end
            if (spc_en && hs_n > 0) check("issue_spacing", cyc - last_hs, 2);
            hs_n++;
            last_hs = cyc;
            if (hs_n >= 5) spc_en = 1'b0;
        end
    endtask

    task automatic step();
        mon();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        run       = 1'b0;
        ins_ready = 1'b1;
        sbq.delete();
        step();
        step();
        rst    = 1'b0;
        hs_n   = 0;
        spc_en = 1'b0;
        mon_en = 1'b1;
    endtask

    // NOP fill with nonzero junk in the register field.
    task automatic load_nops();
        for (int i = 0; i < 32; i++) mem[i] = ins(OPCODE_NOP, i[1:0]);
    endtask

    task automatic load_base();
        load_nops();
        mem[0] = ins(OPCODE_ADD, R1);
        mem[1] = ins(OPCODE_SUB, R1);
        mem[2] = ins(OPCODE_ADD, R2);
        mem[3] = ins(OPCODE_AND, R3);
        mem[4] = ins(OPCODE_ADD, R3);
    endtask

    task automatic run_until_empty(input int lim, input string tag);
        for (int i = 0; i < lim && sbq.size() != 0; i++) step();
        check(tag, sbq.size(), 0);
    endtask

    task automatic wait_halt(input int lim, input string tag);
        for (int i = 0; i < lim && halted !== 1'b1; i++) step();
        check(tag, halted, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen10;
        rst       = 1'b1;
        run       = 1'b0;
        ins_ready = 1'b1;
        load_base();
        @(negedge clk);

        // Reset state and base program with wrap
        do_reset();
        check("rst_addr", addr, 0);
        check("rst_valid", ins_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_icount", icount, 0);
        check("rst_op", op, OPCODE_NOP);
        check("rst_rsel", rsel, 0);
        push(0, OPCODE_ADD, R1);
        push(1, OPCODE_SUB, R1);
        push(2, OPCODE_ADD, R2);
        push(3, OPCODE_AND, R3);
        push(4, OPCODE_ADD, R3);
        push(0, OPCODE_ADD, R1);
        spc_en = 1'b1;
        run = 1'b1;
        step();
        check("lat_fetch_valid", ins_valid, 0);
        check("lat_fetch_addr", addr, 0);
        run = 1'b0;
        step();
        check("lat_issue_valid", ins_valid, 1);
        check("lat_issue_op", op, OPCODE_ADD);
        seen10 = 1'b0;
        for (int i = 0; i < 200 && sbq.size() != 0; i++) begin
            if (addr == 5'd10 && !seen10) begin
                seen10 = 1'b1;
                check("nop_op", op, OPCODE_NOP);
                check("nop_rsel_masked", rsel, 0);
            end
            step();
        end
        check("t1_drain", sbq.size(), 0);
        check("t1_seen_addr10", seen10, 1);
        check("t1_icount", icount, 6);

        // Backpressure during SUB R1
        do_reset();
        load_base();
        push(0, OPCODE_ADD, R1);
        push(1, OPCODE_SUB, R1);
        push(2, OPCODE_ADD, R2);
        push(3, OPCODE_AND, R3);
        push(4, OPCODE_ADD, R3);
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 20 && !(ins_valid === 1'b1 && addr == 5'd1); i++) step();
        check("t2_reach_sub", (ins_valid === 1'b1 && addr == 5'd1), 1);
        ins_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_valid", ins_valid, 1);
            check("stall_op", op, OPCODE_SUB);
            check("stall_rsel", rsel, R1);
            check("stall_addr", addr, 1);
        end
        ins_ready = 1'b1;
        run_until_empty(40, "t2_drain");
        check("t2_icount", icount, 5);

        // HALT at address 2, return to IDLE, restart
        do_reset();
        load_nops();
        mem[0] = ins(OPCODE_ADD, R1);
        mem[1] = ins(OPCODE_SUB, R2);
        mem[2] = ins(OPCODE_HALT, R3);
        push(0, OPCODE_ADD, R1);
        push(1, OPCODE_SUB, R2);
        run = 1'b1;
        wait_halt(30, "t3_halt");
        check("t3_issued", sbq.size(), 0);
        check("t3_halt_valid", ins_valid, 0);
        check("t3_halt_addr", addr, 2);
        check("t3_halt_icount", icount, 2);
        check("t3_halt_op", op, OPCODE_HALT);
        check("t3_halt_rsel_masked", rsel, 0);
        step();
        check("t3_halt_hold", halted, 1);
        run = 1'b0;
        step();
        check("t3_idle_halted", halted, 0);
        check("t3_idle_addr", addr, 0);
        check("t3_idle_icount", icount, 2);
        run = 1'b1;
        push(0, OPCODE_ADD, R1);
        step();
        check("t3_restart_fetch", ins_valid, 0);
        step();
        check("t3_restart_valid", ins_valid, 1);
        check("t3_restart_addr", addr, 0);
        run_until_empty(10, "t3_drain");

        // Undefined opcode sets sticky err
        do_reset();
        load_nops();
        mem[0] = ins(4'h7, R1);
        mem[1] = ins(OPCODE_ADD, R2);
        mem[2] = ins(OPCODE_HALT, R0);
        push(1, OPCODE_ADD, R2);
        run = 1'b1;
        step();
        check("t4_err_before", err, 0);
        step();
        check("t4_err_set", err, 1);
        check("t4_undef_valid", ins_valid, 0);
        check("t4_undef_addr", addr, 1);
        wait_halt(20, "t4_halt");
        check("t4_issued", sbq.size(), 0);
        check("t4_icount", icount, 1);
        run = 1'b0;
        step();
        check("t4_err_idle", err, 1);
        check("t4_idle_halted", halted, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_err_cleared", err, 0);

        // Reset mid-handshake
        do_reset();
        load_base();
        run = 1'b1;
        for (int i = 0; i < 10 && ins_valid !== 1'b1; i++) step();
        check("t5_reach_issue", ins_valid, 1);
        rst = 1'b1;
        sbq.delete();
        step();
        check("t5_valid", ins_valid, 0);
        check("t5_addr", addr, 0);
        check("t5_icount", icount, 0);
        rst = 1'b0;
        step();
        check("t5_icount_after", icount, 0);

        // icount saturation
        do_reset();
        for (int i = 0; i < 32; i++) mem[i] = ins(OPCODE_ADD, R0);
        mon_en = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 201; i++) step();
        check("t6_icount_mid", icount, 100);
        for (int i = 0; i < 400; i++) step();
        check("t6_icount_sat", icount, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
